ov7670_capture_ctrl: RTL and testbench
======================================

OV7670_CAPTURE_CTRL -- requirements
Module: ov7670_capture_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 17: width of the frame-buffer pixel address.
REQ-002 SHALL have parameter H_PIXELS, default 320: expected pixels per line.
REQ-003 SHALL have parameter V_LINES, default 240: expected lines per frame.
REQ-004 SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that arms a capture.
REQ-007 SHALL have port continuous, input, 1: sampled at start; 1 means re-arm after every frame.
REQ-008 SHALL have port abort, input, 1: return to IDLE at once.
REQ-009 SHALL have port PCLK, input, 1: camera pixel clock, asynchronous to clk.
REQ-010 SHALL have port HREF, input, 1: line-valid from the camera.
REQ-011 SHALL have port VSYNC, input, 1: frame-blanking from the camera, high between frames.
REQ-012 SHALL have port data, input, 10: camera pixel bus; only bits [7:0] are used.
REQ-013 SHALL have port wr_en, output, 1: one-cycle frame-buffer write strobe.
REQ-014 SHALL have port wr_addr, output, AWIDTH: pixel address for the write.
REQ-015 SHALL have port wr_data, output, 16: RGB565 pixel for the write.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each frame.
REQ-018 SHALL have port frame_err, output, 1: sticky flag for a geometry mismatch; cleared by start or reset.

Function
REQ-019 SHALL pass PCLK, HREF, VSYNC and data[7:0] through matched 2-flop synchronizers.
REQ-020 SHALL derive from the synchronized signals one-cycle internal events: pclk_rise, href_fall, vsync_fall and vsync_rise.
REQ-021 SHALL require clk to be at least 4x the PCLK frequency; behaviour at lower ratios is undefined.
REQ-022 SHALL implement four FSM states: IDLE, WAIT_VSYNC, CAPTURE and DONE.
REQ-023 SHALL move IDLE->WAIT_VSYNC on start, latching continuous and clearing frame_err.
REQ-024 SHALL move WAIT_VSYNC->CAPTURE on vsync_fall, clearing the address, column, row and byte-phase counters.
REQ-025 SHALL, in CAPTURE on pclk_rise with HREF high, handle bytes by phase: phase 0 latches the byte as wr_data[15:8]; phase 1 forms wr_data[7:0] and triggers a write; phase then toggles.
REQ-026 SHALL assert wr_en on the clk edge after the pclk_rise cycle of phase 1, with wr_addr equal to the current address; the address and column then increment by 1.
REQ-027 SHALL suppress writes, while still counting, once the column reaches H_PIXELS or the address reaches H_PIXELS*V_LINES.
REQ-028 SHALL, on href_fall in CAPTURE, set frame_err if the column is not H_PIXELS or phase is 1, then zero the column and phase and increment the row.
REQ-029 SHALL move CAPTURE->DONE on vsync_rise, setting frame_err if the row is not V_LINES.
REQ-030 SHALL stay in DONE for exactly one cycle with frame_done high, then go to WAIT_VSYNC if the latched continuous is 1, otherwise to IDLE.
REQ-031 SHALL, on abort in any state, go to IDLE on the next edge with wr_en low and frame_done not pulsed; abort takes priority over start and all camera events.
REQ-032 SHALL ignore start outside IDLE.
REQ-033 SHALL ignore camera events in IDLE; in WAIT_VSYNC it SHALL ignore everything except vsync_fall, so a partial frame is never captured.
REQ-034 SHALL process href_fall before vsync_rise when both occur in the same cycle, so the last line is counted.
REQ-035 SHALL make all outputs registered.

Reset
REQ-036 SHALL, while rst_n=0 at a clk edge, set state=IDLE and wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_err=0, and clear all counters and synchronizers.
REQ-037 SHALL treat reset mid-frame like abort, and SHALL then wait for a fresh vsync_fall after the next start.

Verification (H_PIXELS=4, V_LINES=2, clk = 8x PCLK)
REQ-038 SHALL cover a nominal frame: start, VSYNC fall, 2 lines of 8 bytes 0x00..0x0F -> 8 writes at addr 0..7 with data 0x0001,0x0203,...,0x0E0F, then one frame_done pulse, frame_err=0, end state IDLE.
REQ-039 SHALL cover a short line of 6 bytes -> 3 writes for that line, frame_err=1 at frame end, frame_done still pulsed.
REQ-040 SHALL cover a long line of 10 bytes -> only 4 writes for that line, next line starting at addr 4, frame_err=1.
REQ-041 SHALL cover start given mid-frame with VSYNC low -> no writes until the next VSYNC high->low, then a full 8-write frame.
REQ-042 SHALL cover continuous=1 over two frames -> 16 writes with addr 0..7 twice, two frame_done pulses, busy high throughout.
REQ-043 SHALL cover abort after the 3rd write -> IDLE next cycle, busy=0, no further wr_en, no frame_done.

Source files
------------

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 byte-stream capture: synchronizes the camera bus into clk, pairs bytes
// into RGB565 pixels and writes them to a frame buffer with geometry checking.
module ov7670_capture_ctrl #(
    parameter int AWIDTH   = 17,
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic              PCLK,
    input  logic              HREF,
    input  logic              VSYNC,
    input  logic [9:0]        data,
    output logic              wr_en,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    typedef enum logic [1:0] {IDLE, WAIT_VSYNC, CAPTURE, DONE} state_t;

    localparam logic [15:0] H_CNT        = 16'(H_PIXELS);
    localparam logic [15:0] V_CNT        = 16'(V_LINES);
    localparam logic [31:0] FRAME_PIXELS = 32'(H_PIXELS * V_LINES);

    state_t              state_q, state_d;
    logic [10:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]          prev_q, prev_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [15:0]         col_q, col_d, row_q, row_d;
    logic                phase_q, phase_d;
    logic                cont_q, cont_d;
    logic                wr_en_q, wr_en_d;
    logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q, frame_err_d;

    logic                pclk_s, href_s, vsync_s;
    logic [7:0]          data_s;
    logic                pclk_rise, href_fall, vsync_fall, vsync_rise;
    logic                write_ok;
    logic                unused_data;

    assign unused_data = ^data[9:8];

    // Bus layout through both sync stages: {PCLK, HREF, VSYNC, data[7:0]}
    assign sync1_d = {PCLK, HREF, VSYNC, data[7:0]};
    assign sync2_d = sync1_q;
    assign prev_d  = sync2_q[10:8];

    assign pclk_s  = sync2_q[10];
    assign href_s  = sync2_q[9];
    assign vsync_s = sync2_q[8];
    assign data_s  = sync2_q[7:0];

    assign pclk_rise  = pclk_s & ~prev_q[2];
    assign href_fall  = ~href_s & prev_q[1];
    assign vsync_fall = ~vsync_s & prev_q[0];
    assign vsync_rise = vsync_s & ~prev_q[0];

    assign write_ok = (col_q < H_CNT) && (32'(addr_q) < FRAME_PIXELS);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        col_d        = col_q;
        row_d        = row_q;
        phase_d      = phase_q;
        cont_d       = cont_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = WAIT_VSYNC;
                    cont_d      = continuous;
                    frame_err_d = 1'b0;
                end
            end
            WAIT_VSYNC: begin
                if (vsync_fall) begin
                    state_d = CAPTURE;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    phase_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (pclk_rise && href_s) begin
                    if (!phase_q) begin
                        wr_data_d[15:8] = data_s;
                        phase_d         = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        col_d   = col_q + 16'd1;
                        // Overlong lines/frames keep counting columns but the
                        // address stays put so the next line lands correctly.
                        if (write_ok) begin
                            wr_en_d        = 1'b1;
                            wr_addr_d      = addr_q;
                            wr_data_d[7:0] = data_s;
                            addr_d         = addr_q + 1'b1;
                        end
                    end
                end
                if (href_fall) begin
                    if (col_q != H_CNT || phase_q) frame_err_d = 1'b1;
                    col_d   = '0;
                    phase_d = 1'b0;
                    row_d   = row_q + 16'd1;
                end
                // row_d already includes a line ending in this same cycle
                if (vsync_rise) begin
                    if (row_d != V_CNT) frame_err_d = 1'b1;
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d = cont_q ? WAIT_VSYNC : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d      = IDLE;
            wr_en_d      = 1'b0;
            frame_done_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            addr_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            phase_q      <= 1'b0;
            cont_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            addr_q       <= addr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            phase_q      <= phase_d;
            cont_q       <= cont_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Bench for ov7670_capture_ctrl with a 4x2 frame and PCLK at 1/8 of clk.
module tb_ov7670_capture_ctrl;

    localparam int AW = 17;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int W  = AW + 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          abort = 1'b0;
    logic          PCLK = 1'b0;
    logic          HREF = 1'b0;
    logic          VSYNC = 1'b1;
    logic [9:0]    data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          frame_done;
    logic          frame_err;

    ov7670_capture_ctrl #(.AWIDTH(AW), .H_PIXELS(H), .V_LINES(V)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .abort(abort), .PCLK(PCLK), .HREF(HREF), .VSYNC(VSYNC), .data(data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic [7:0]   frame_bytes[$];
    int           frame_lens[$];
    logic         model_err;
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_writes = 0;
    int           n_done = 0;
    int           busy_drop = 0;
    logic         busy_watch = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            n_writes++;
            if (exp_q.size() == 0) chk("unexpected_write", 64'({wr_addr, wr_data}), 64'h0);
            else chk("write_addr_data", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
        end
        if (frame_done) n_done++;
        if (busy_watch && !busy) busy_drop++;
    end

    // reference model: pixels in byte order, rows of H, frame capped at H*V
    task automatic run_model();
        int k = 0;
        int addr = 0;
        model_err = (frame_lens.size() != V);
        foreach (frame_lens[l]) begin
            int len = frame_lens[l];
            int pix = 0;
            if (len != 2 * H) model_err = 1'b1;
            for (int p = 0; p < len / 2; p++) begin
                logic [7:0] hi = frame_bytes[k];
                logic [7:0] lo = frame_bytes[k + 1];
                k += 2;
                if (pix < H && addr < H * V) begin
                    exp_q.push_back({AW'(addr), hi, lo});
                    addr++;
                end
                pix++;
            end
            if (len % 2 == 1) k++;
        end
    endtask

    task automatic prep_frame(input int nl, input int l0, input int l1, input int l2, input bit rnd);
        int lens[3];
        int cnt = 0;
        lens[0] = l0; lens[1] = l1; lens[2] = l2;
        frame_lens.delete();
        frame_bytes.delete();
        for (int l = 0; l < nl; l++) begin
            frame_lens.push_back(lens[l]);
            for (int i = 0; i < lens[l]; i++) begin
                frame_bytes.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(cnt));
                cnt++;
            end
        end
        run_model();
    endtask

    // driver tasks
    task automatic pclk_cycle(input logic h, input logic [7:0] d);
        PCLK = 1'b0;
        HREF = h;
        data = {2'($urandom_range(0, 3)), d};
        #40;
        PCLK = 1'b1;
        #40;
    endtask

    task automatic idle_pclk(input int n);
        for (int i = 0; i < n; i++) pclk_cycle(1'b0, 8'h00);
    endtask

    task automatic send_frame();
        int k = 0;
        VSYNC = 1'b1;
        idle_pclk(2);
        VSYNC = 1'b0;
        idle_pclk(2);
        foreach (frame_lens[l]) begin
            for (int i = 0; i < frame_lens[l]; i++) begin
                pclk_cycle(1'b1, frame_bytes[k]);
                k++;
            end
            idle_pclk(2);
        end
        VSYNC = 1'b1;
        idle_pclk(3);
    endtask

    task automatic pulse_start(input logic c);
        @(negedge clk);
        start = 1'b1;
        continuous = c;
        @(negedge clk);
        start = 1'b0;
        continuous = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    typedef struct {
        string name;
        int    nlines;
        int    len0;
        int    len1;
        int    len2;
        int    exp_writes;
        logic  exp_err;
    } frame_vec_t;

    frame_vec_t vecs[6];

    initial begin
        int w0;
        int d0;
        vecs[0] = '{"nominal",    2, 8,  8, 0, 8, 1'b0};
        vecs[1] = '{"short_line", 2, 6,  8, 0, 7, 1'b1};
        vecs[2] = '{"long_line",  2, 10, 8, 0, 8, 1'b1};
        vecs[3] = '{"odd_line",   2, 7,  8, 0, 7, 1'b1};
        vecs[4] = '{"extra_line", 3, 8,  8, 8, 8, 1'b1};
        vecs[5] = '{"one_line",   1, 8,  0, 0, 4, 1'b1};

        repeat (4) @(negedge clk);
        chk("rst_wr_en", 64'(wr_en), 64'h0);
        chk("rst_wr_addr", 64'(wr_addr), 64'h0);
        chk("rst_wr_data", 64'(wr_data), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_frame_done", 64'(frame_done), 64'h0);
        chk("rst_frame_err", 64'(frame_err), 64'h0);
        rst_n = 1'b1;
        idle_pclk(2);
        chk("idle_busy", 64'(busy), 64'h0);

        // table-driven frames with hand-computed write counts
        for (int t = 0; t < 6; t++) begin
            prep_frame(vecs[t].nlines, vecs[t].len0, vecs[t].len1, vecs[t].len2, 1'b0);
            w0 = n_writes;
            d0 = n_done;
            pulse_start(1'b0);
            chk({vecs[t].name, "_busy_armed"}, 64'(busy), 64'h1);
            send_frame();
            chk({vecs[t].name, "_writes"}, 64'(n_writes - w0), 64'(vecs[t].exp_writes));
            chk({vecs[t].name, "_done"}, 64'(n_done - d0), 64'h1);
            chk({vecs[t].name, "_err"}, 64'(frame_err), 64'(vecs[t].exp_err));
            chk({vecs[t].name, "_busy_end"}, 64'(busy), 64'h0);
            chk({vecs[t].name, "_exp_left"}, 64'(exp_q.size()), 64'h0);
            exp_q.delete();
        end

        // start while VSYNC already low: that frame must be skipped entirely
        w0 = n_writes;
        d0 = n_done;
        VSYNC = 1'b0;
        idle_pclk(2);
        for (int i = 0; i < 4; i++) pclk_cycle(1'b1, 8'(i));
        pulse_start(1'b0);
        for (int i = 4; i < 8; i++) pclk_cycle(1'b1, 8'(i));
        idle_pclk(2);
        for (int i = 0; i < 8; i++) pclk_cycle(1'b1, 8'(i));
        idle_pclk(2);
        VSYNC = 1'b1;
        idle_pclk(3);
        chk("midstart_no_writes", 64'(n_writes - w0), 64'h0);
        chk("midstart_no_done", 64'(n_done - d0), 64'h0);
        chk("midstart_busy", 64'(busy), 64'h1);
        prep_frame(2, 8, 8, 0, 1'b0);
        send_frame();
        chk("midstart_writes", 64'(n_writes - w0), 64'h8);
        chk("midstart_done", 64'(n_done - d0), 64'h1);
        chk("midstart_err", 64'(frame_err), 64'h0);
        chk("midstart_exp_left", 64'(exp_q.size()), 64'h0);
        exp_q.delete();

        // continuous capture over two frames
        w0 = n_writes;
        d0 = n_done;
        busy_drop = 0;
        pulse_start(1'b1);
        busy_watch = 1'b1;
        for (int f = 0; f < 2; f++) begin
            prep_frame(2, 8, 8, 0, 1'b0);
            send_frame();
        end
        busy_watch = 1'b0;
        chk("cont_writes", 64'(n_writes - w0), 64'd16);
        chk("cont_done", 64'(n_done - d0), 64'h2);
        chk("cont_busy_drops", 64'(busy_drop), 64'h0);
        chk("cont_still_busy", 64'(busy), 64'h1);
        pulse_abort();
        chk("cont_abort_idle", 64'(busy), 64'h0);
        exp_q.delete();

        // abort after the third write
        w0 = n_writes;
        d0 = n_done;
        prep_frame(2, 8, 8, 0, 1'b0);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        pulse_start(1'b0);
        fork
            send_frame();
            begin
                int t = 0;
                while (n_writes - w0 < 3 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 5000) chk("abort_wait_timeout", 64'h1, 64'h0);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy_next", 64'(busy), 64'h0);
                chk("abort_wr_en_next", 64'(wr_en), 64'h0);
            end
        join
        chk("abort_writes", 64'(n_writes - w0), 64'h3);
        chk("abort_no_done", 64'(n_done - d0), 64'h0);
        chk("abort_busy_end", 64'(busy), 64'h0);
        exp_q.delete();

        // randomized geometry and pixel values against the model
        for (int r = 0; r < 8; r++) begin
            int nl = $urandom_range(1, 3);
            prep_frame(nl, $urandom_range(6, 10), $urandom_range(6, 10),
                       $urandom_range(6, 10), 1'b1);
            d0 = n_done;
            pulse_start(1'b0);
            send_frame();
            chk("rand_done", 64'(n_done - d0), 64'h1);
            chk("rand_err", 64'(frame_err), 64'(model_err));
            chk("rand_exp_left", 64'(exp_q.size()), 64'h0);
            exp_q.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
